// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA scan driver slice:
//   - default 640x480@60 Hz timing constants and line/frame totals
//   - scan_ctl_t, the element carried down the sync/blank delay line
//   - colour-bar constants and a lookup helper for the test pattern
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int BAR_COUNT = 8;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vis;
        logic [2:0] bar;
    } scan_ctl_t;

    // Idle state of the syncs: both inactive (high), blanked.
    localparam scan_ctl_t SCAN_CTL_RESET = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, bar: 3'd0};

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    // Left-to-right bar order, packed as {R, G, B}.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = BAR_WHITE;
            3'd1:    rgb = BAR_YELLOW;
            3'd2:    rgb = BAR_CYAN;
            3'd3:    rgb = BAR_GREEN;
            3'd4:    rgb = BAR_MAGENTA;
            3'd5:    rgb = BAR_RED;
            3'd6:    rgb = BAR_BLUE;
            default: rgb = BAR_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// ---------------------------------------------------------------------------
// vga_scan_driver_if
// Bundles the scan driver's pixel-path and DAC signals.
//   DrawX, DrawY         scan position towards the colour mapper
//   Red, Green, Blue     colour returned by the mapper
//   VGA_R/G/B            registered DAC colour
//   VGA_HS, VGA_VS       syncs, active low
//   VGA_BLANK_N          high in the visible area
//   VGA_SYNC_N           composite sync, unused (tied low)
//   VGA_CLK              pixel clock (half the system clock)
//   frame_tick           one-clock pulse at the start of vertical blank
// modport master: the scan driver.  modport slave: mapper/DAC side.
// ---------------------------------------------------------------------------
interface vga_scan_driver_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;
    logic       frame_tick;

    modport master (
        output DrawX, DrawY,
        input  Red, Green, Blue,
        output VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        output frame_tick
    );

    modport slave (
        input  DrawX, DrawY,
        output Red, Green, Blue,
        input  VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        input  frame_tick
    );
endinterface

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Shift register of DEPTH scan_ctl_t stages, advanced when shift_en is high.
// DEPTH = 0 gives a combinational pass-through.
//   clk       clock
//   srst      synchronous active-high reset (stages load SCAN_CTL_RESET)
//   shift_en  advance the line by one stage
//   d         input element
//   q         element delayed by DEPTH shifts
// ---------------------------------------------------------------------------
module vga_delay_line
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      srst,
    input  logic      shift_en,
    input  scan_ctl_t d,
    output scan_ctl_t q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            // tap[i] is the input of stage i; tap[DEPTH] is the line output.
            scan_ctl_t tap [DEPTH+1];
            assign tap[0] = d;

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                scan_ctl_t stage_reg;
                always_ff @(posedge clk) begin
                    if (srst) begin
                        stage_reg <= SCAN_CTL_RESET;
                    end else if (shift_en) begin
                        stage_reg <= tap[gi];
                    end
                end
                assign tap[gi+1] = stage_reg;
            end

            assign q = tap[DEPTH];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_driver.sv
// ---------------------------------------------------------------------------
// vga_scan_driver
// Raster source for the display path. Generates the scan position for the
// colour mapper, delays sync/blank to match the mapper latency (PIPE_LAT
// pixel ticks) and drives registered VGA DAC outputs plus a frame tick.
//
// Ports:
//   Clk        system clock (pixel clock is Clk/2)
//   Reset      synchronous, active-high
//   test_mode  colour-bar select (only with VGA_TEST_PATTERN_EN defined)
//   vga        vga_scan_driver_if.master: DrawX/DrawY, Red/Green/Blue in,
//              VGA_* DAC/sync outputs, frame_tick
//
// Build option: define VGA_TEST_PATTERN_EN to add test_mode and the
// eight-bar test pattern. Undefined, the input colour is always used.
// ---------------------------------------------------------------------------
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int PIPE_LAT  = 1
) (
    input  logic                Clk,
    input  logic                Reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                test_mode,
`endif
    vga_scan_driver_if.master   vga
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic        pix_en_reg;
    logic [9:0]  hc_reg, hc_next;
    logic [9:0]  vc_reg, vc_next;
    logic        frame_tick_reg;
    logic        hs_reg, vs_reg, blank_n_reg;
    logic [7:0]  r_reg, g_reg, b_reg;

    scan_ctl_t   ctl_raw;
    scan_ctl_t   ctl_dly;
    logic [23:0] colour_next;

    // ---------------------------------------------------------------
    // Counter next-state
    // ---------------------------------------------------------------
    always_comb begin
        hc_next = hc_reg + 10'd1;
        vc_next = vc_reg;
        if (hc_reg == H_LAST) begin
            hc_next = '0;
            vc_next = (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;
        end
    end

    // ---------------------------------------------------------------
    // Raw (undelayed) sync, visibility and bar index for the current
    // position
    // ---------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_VISIBLE / BAR_COUNT);
    logic [9:0] bar_full;
    always_comb begin
        bar_full = hc_reg / BAR_W;
    end
`endif

    always_comb begin
        ctl_raw     = SCAN_CTL_RESET;
        ctl_raw.hs  = !((hc_reg >= HS_START) && (hc_reg < HS_END));
        ctl_raw.vs  = !((vc_reg >= VS_START) && (vc_reg < VS_END));
        ctl_raw.vis = (hc_reg < H_VIS_END) && (vc_reg < V_VIS_END);
`ifdef VGA_TEST_PATTERN_EN
        // Clamp keeps the index in range for the porch/sync region, where
        // the colour is blanked anyway.
        ctl_raw.bar = (bar_full > 10'd7) ? 3'd7 : bar_full[2:0];
`else
        ctl_raw.bar = 3'd0;
`endif
    end

    // Align sync/blank/bar with the mapper's colour latency.
    vga_delay_line #(
        .DEPTH    (PIPE_LAT)
    ) u_delay (
        .clk      (Clk),
        .srst     (Reset),
        .shift_en (pix_en_reg),
        .d        (ctl_raw),
        .q        (ctl_dly)
    );

    // ---------------------------------------------------------------
    // Colour select for the output register
    // ---------------------------------------------------------------
    always_comb begin
        colour_next = {vga.Red, vga.Green, vga.Blue};
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            colour_next = bar_colour(ctl_dly.bar);
        end
`endif
        if (!ctl_dly.vis) begin
            colour_next = '0;
        end
    end

`ifndef VGA_TEST_PATTERN_EN
    // The bar index only matters for the test pattern.
    logic unused_bar;
    assign unused_bar = &{1'b0, ctl_dly.bar};
`endif

    // ---------------------------------------------------------------
    // Sequential state: pixel enable, counters, output register
    // ---------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_en_reg     <= 1'b0;
            hc_reg         <= '0;
            vc_reg         <= '0;
            frame_tick_reg <= 1'b0;
            hs_reg         <= 1'b1;
            vs_reg         <= 1'b1;
            blank_n_reg    <= 1'b0;
            r_reg          <= '0;
            g_reg          <= '0;
            b_reg          <= '0;
        end else begin
            pix_en_reg     <= ~pix_en_reg;
            frame_tick_reg <= 1'b0;
            if (pix_en_reg) begin
                hc_reg         <= hc_next;
                vc_reg         <= vc_next;
                // Fires on the tick that enters the first blanked line,
                // independent of the delay line.
                frame_tick_reg <= (hc_next == 10'd0) && (vc_next == V_VIS_END);
                hs_reg         <= ctl_dly.hs;
                vs_reg         <= ctl_dly.vs;
                blank_n_reg    <= ctl_dly.vis;
                r_reg          <= colour_next[23:16];
                g_reg          <= colour_next[15:8];
                b_reg          <= colour_next[7:0];
            end
        end
    end

    assign vga.DrawX       = hc_reg;
    assign vga.DrawY       = vc_reg;
    assign vga.VGA_R       = r_reg;
    assign vga.VGA_G       = g_reg;
    assign vga.VGA_B       = b_reg;
    assign vga.VGA_HS      = hs_reg;
    assign vga.VGA_VS      = vs_reg;
    assign vga.VGA_BLANK_N = blank_n_reg;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_CLK     = pix_en_reg;
    assign vga.frame_tick  = frame_tick_reg;

endmodule

// File: tb/tb_vga_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_driver
// Scoreboard bench for vga_scan_driver with a shrunken raster so that
// several frames fit in a short run. Each clock the stimulus side drives a
// random mapper colour (and test_mode when built with VGA_TEST_PATTERN_EN),
// computes the expected outputs from the raster rules using the pixel-tick
// count since reset, and queues them; the monitor pops one entry per clock
// and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_vga_scan_driver;
    import vga_pkg::*;

    localparam int HV = 16, HF = 2, HSY = 4, HB = 3;
    localparam int VV = 6,  VF = 1, VSY = 2, VB = 2;
    localparam int LAT   = 2;
    localparam int HT    = HV + HF + HSY + HB;
    localparam int VT    = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT;

    typedef struct {
        int x, y, r, g, b, hs, vs, bn, ft, vclk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    vga_scan_driver_if vif();

    vga_scan_driver #(
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
        .PIPE_LAT  (LAT)
    ) dut (
        .Clk       (clk),
        .Reset     (rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .vga       (vif.master)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle_n  = 0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic void check(string name, int act, int expv, int cyc);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, expv);
        end
    endfunction

    // Scan position held during pixel tick t (t = 1 is the first tick).
    function automatic void pos_of(input int t, output int h, output int v);
        int p;
        p = (t - 1) % FRAME;
        h = p % HT;
        v = p / HT;
    endfunction

    // ---------------------------------------------------------------
    // Stimulus + reference model
    // ---------------------------------------------------------------
    exp_t cur;
    bit   pix_m;
    int   tick_m;

    task automatic do_cycle(input logic r_in);
        int h, v, hd, vd, vis, idx;
        logic [23:0] rgb, col;
        bit tm;
        @(negedge clk);
        rst = r_in;
        rgb = 24'($urandom);
        vif.Red   = rgb[23:16];
        vif.Green = rgb[15:8];
        vif.Blue  = rgb[7:0];
        tm = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        tm = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        test_mode = tm;
`endif
        if (r_in) begin
            cur = '{x: 0, y: 0, r: 0, g: 0, b: 0, hs: 1, vs: 1, bn: 0, ft: 0, vclk: 0};
            pix_m  = 1'b0;
            tick_m = 0;
        end else if (!pix_m) begin
            pix_m    = 1'b1;
            cur.vclk = 1;
            cur.ft   = 0;
        end else begin
            pix_m    = 1'b0;
            tick_m++;
            cur.vclk = 0;
            pos_of(tick_m + 1, h, v);
            cur.x  = h;
            cur.y  = v;
            cur.ft = (h == 0 && v == VV) ? 1 : 0;
            if (tick_m - LAT >= 1) begin
                pos_of(tick_m - LAT, hd, vd);
                cur.hs = (hd >= HV + HF && hd < HV + HF + HSY) ? 0 : 1;
                cur.vs = (vd >= VV + VF && vd < VV + VF + VSY) ? 0 : 1;
                vis    = (hd < HV && vd < VV) ? 1 : 0;
                idx    = hd / (HV / 8);
                if (idx > 7) idx = 7;
            end else begin
                cur.hs = 1;
                cur.vs = 1;
                vis    = 0;
                idx    = 0;
            end
            col = tm ? bar_tab[idx] : rgb;
            if (vis == 0) col = 24'h0;
            cur.bn = vis;
            cur.r  = int'(col[23:16]);
            cur.g  = int'(col[15:8]);
            cur.b  = int'(col[7:0]);
        end
        exp_q.push_back(cur);
    endtask

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cycle_n++;
                check("drawx",      int'(vif.DrawX),       e.x,    cycle_n);
                check("drawy",      int'(vif.DrawY),       e.y,    cycle_n);
                check("vga_r",      int'(vif.VGA_R),       e.r,    cycle_n);
                check("vga_g",      int'(vif.VGA_G),       e.g,    cycle_n);
                check("vga_b",      int'(vif.VGA_B),       e.b,    cycle_n);
                check("vga_hs",     int'(vif.VGA_HS),      e.hs,   cycle_n);
                check("vga_vs",     int'(vif.VGA_VS),      e.vs,   cycle_n);
                check("blank_n",    int'(vif.VGA_BLANK_N), e.bn,   cycle_n);
                check("frame_tick", int'(vif.frame_tick),  e.ft,   cycle_n);
                check("vga_clk",    int'(vif.VGA_CLK),     e.vclk, cycle_n);
                check("sync_n",     int'(vif.VGA_SYNC_N),  0,      cycle_n);
            end
        end
    end

    // ---------------------------------------------------------------
    // Test sequence: reset, ~1.5 frames, mid-frame reset, >2 frames
    // ---------------------------------------------------------------
    initial begin
        vif.Red   = 8'h00;
        vif.Green = 8'h00;
        vif.Blue  = 8'h00;
        for (int i = 0; i < 3; i++) do_cycle(1'b1);
        for (int i = 0; i < 800; i++) do_cycle(1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b1);
        for (int i = 0; i < 1300; i++) do_cycle(1'b0);
        @(posedge clk);
        #2;
        check("queue_drain", exp_q.size(), 0, cycle_n);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Raster source for the display path. Generates the 640x480@60 Hz scan position (`DrawX`, `DrawY`) that the colour mapper and sprite blocks consume, and takes back the mapper's `Red`/`Green`/`Blue`. Delays sync and blank to match the mapper's latency, then drives registered VGA DAC outputs and a once-per-frame tick for game logic.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch / sync / back porch, in pixels
- `V_VISIBLE`, 480: visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch / sync / back porch, in lines
- `PIPE_LAT`, 1: pixel ticks from a `DrawX`/`DrawY` change to the matching valid `Red`/`Green`/`Blue`; legal range 0..4

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  system clock, 50 MHz
- `Reset`  in  1  synchronous, active-high
- `Red`, `Green`, `Blue`  in  8 each  pixel colour from the mapper
- `test_mode`  in  1  colour-bar select; present only with the macro
- `DrawX`, `DrawY`  out  10 each  current scan position
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  DAC colour
- `VGA_HS`, `VGA_VS`  out  1  syncs, active low
- `VGA_BLANK_N`  out  1  high in the visible area
- `VGA_SYNC_N`  out  1  tied 0
- `VGA_CLK`  out  1  25 MHz pixel clock
- `frame_tick`  out  1  one-`Clk` pulse at the start of vertical blank

## Operation
- `pix_en` is an internal toggle register: 0 after reset, then inverts every `Clk`. `VGA_CLK` equals `pix_en`.
- All scan state advances only in cycles where `pix_en`=1 (a "pixel tick").
- Counters:
  - `hc` counts 0..H_TOTAL-1 (800), then wraps to 0.
  - On `hc` wrap, `vc` counts 0..V_TOTAL-1 (525), then wraps to 0.
  - `DrawX`=`hc` and `DrawY`=`vc`, driven straight from the registers.
- Raw, undelayed signals:
  - `hs_raw` = 0 when `hc` is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. [656,752).
  - `vs_raw` = 0 when `vc` is in [490,492).
  - `vis_raw` = (`hc`<640 && `vc`<480).
- Delay line: a shift register of depth `PIPE_LAT`, advanced on pixel ticks, carries {hs, vs, vis}. With `PIPE_LAT`=0 the raw values pass through combinationally into the output register.
- Output register, loaded on pixel ticks:
  - `VGA_HS`, `VGA_VS`, `VGA_BLANK_N` take the delayed values.
  - `VGA_R/G/B` take `Red/Green/Blue` when delayed vis=1, otherwise 0x00.
- `frame_tick`: high for exactly one `Clk`, in the cycle after the pixel tick on which (`hc`,`vc`) becomes (0,480). Its timing is not affected by `PIPE_LAT`.
- Counter widths are 10 bits. Wrap-around compares against TOTAL-1 by equality; the counters never exceed it.

## Timing
- Reset values:
  - `hc`, `vc`, `pix_en`: 0
  - `VGA_HS`, `VGA_VS`: 1
  - `VGA_BLANK_N`, `VGA_R/G/B`, `frame_tick`, `VGA_CLK`: 0
  - Delay line: {hs=1, vs=1, vis=0}
- Reset asserted mid-frame overrides everything in that same `Clk` edge. The first pixel tick after reset deasserts is at the second `Clk` edge; on it `hc` becomes 1.
- DAC outputs lag the raw position by `PIPE_LAT`+1 pixel ticks.
- `VGA_HS` low duration: 96 pixel ticks = 192 `Clk`. Line period: 1600 `Clk`. Frame period: 840000 `Clk`.
- Outputs change only on `Clk` edges that follow a pixel tick, i.e. aligned to the rising edge of `VGA_CLK`.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - Adds the `test_mode` port.
  - When `test_mode`=1, the colour sampled in the visible area is 8 vertical bars, each 80 pixels wide, selected by the delayed `hc[9:7]`-equivalent index `hc`/80. Bar order: white, yellow, cyan, green, magenta, red, blue, black (channels 0xFF/0x00).
  - The input colour is ignored while `test_mode`=1.
  - The index is delayed along with vis so the bars are aligned with blanking.
- Not defined: no `test_mode` port; behaviour is exactly as above.

## Structure
- Package `vga_pkg`:
  - Default timing constants and H_TOTAL/V_TOTAL.
  - `typedef struct packed {logic hs, vs, vis; logic [2:0] bar;} scan_ctl_t` for the delay-line element.
  - Bar colour constants.
- Sub-module `vga_delay_line`: parameterised depth, `scan_ctl_t` payload, shift-enable input. This is the one natural split.

## Test plan
- Reset: hold `Reset` for 3 cycles mid-frame -> all outputs equal their reset values; after release `DrawX` goes 1, 2, 3 on alternate `Clk`s.
- Horizontal timing, `PIPE_LAT`=1: `VGA_HS` falls 2 pixel ticks after `hc`=656 and stays low for 192 `Clk`; line period is 1600 `Clk`.
- Vertical timing: `VGA_VS` low for exactly 2 lines starting at `vc`=490 (delayed 2 ticks). `frame_tick` fires once per 840000 `Clk`, one cycle after `vc` becomes 480.
- Blanking: drive `Red/Green/Blue`=0xFF constant -> `VGA_R/G/B`=0 whenever `VGA_BLANK_N`=0; 0xFF on all 640x480 visible pixels.
- Latency, `PIPE_LAT`=3: mapper model returns `DrawX[7:0]` as `Red` with a 3-tick delay -> the first visible `VGA_R` on every line is 0x00 and the last is 0x7F (639 mod 256).
- With `VGA_TEST_PATTERN_EN`, `test_mode`=1: pixel 0 is FFFFFF, pixel 80 is FFFF00, pixel 639 is 000000; `Red` input is ignored.
